// File: rtl/ddr_op_scheduler_if.sv
// Request/completion handshake and status bundle between the register-level
// start pulses, the DDR3 engines and the operation scheduler.
interface ddr_op_scheduler_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic [3:0]       req_i;
    logic [3:0]       done_i;
    logic [3:0]       start_o;
    logic             busy_o;
    logic [3:0]       active_o;
    logic [3:0]       pending_o;
    logic [CNT_W-1:0] drop_cnt_o;
    logic [CNT_W-1:0] tmo_cnt_o;
    logic             tmo_flag_o;

    modport master (
        output req_i, done_i,
        input  start_o, busy_o, active_o, pending_o, drop_cnt_o, tmo_cnt_o, tmo_flag_o
    );

    modport slave (
        input  req_i, done_i,
        output start_o, busy_o, active_o, pending_o, drop_cnt_o, tmo_cnt_o, tmo_flag_o
    );
endinterface

// File: rtl/ddr_op_scheduler.sv
// Serializes DDR3 engine requests: round-robin single grants, with pattern
// WR+RD pending together launched as one RW pair; tracks drops and timeouts.
module ddr_op_scheduler #(
    parameter int unsigned      TMO_W   = 24,
    parameter logic [TMO_W-1:0] TMO_MAX = 24'hFFFFFF,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    ddr_op_scheduler_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_e;

    state_e           state_q, state_d;
    logic [3:0]       pending_q, pending_d;
    logic [3:0]       active_q, active_d;
    logic [3:0]       start_q, start_d;
    logic [3:0]       mask_q, mask_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             flag_q, flag_d;

    logic [3:0]       accept, dropped, grant, done_all;
    logic [2:0]       ndrop;
    logic [CNT_W:0]   drop_sum;
    logic [1:0]       idx, next_ptr;
    logic             found, finish;

    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        start_d   = '0;
        mask_d    = mask_q;
        ptr_d     = ptr_q;
        tmo_d     = tmo_q;
        tcnt_d    = tcnt_q;
        flag_d    = flag_q;
        grant     = '0;
        found     = 1'b0;
        idx       = '0;
        finish    = 1'b0;
        done_all  = '0;

        accept    = bus.req_i & ~pending_q & ~active_q;
        dropped   = bus.req_i & (pending_q | active_q);
        ndrop     = 3'(dropped[0]) + 3'(dropped[1]) + 3'(dropped[2]) + 3'(dropped[3]);
        drop_sum  = {1'b0, drop_q} + (CNT_W+1)'(ndrop);
        drop_d    = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        pending_d = pending_q | accept;

        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && pending_q[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        // Pattern WR+RD pending together beat the round-robin order.
        if (pending_q[0] && pending_q[1]) begin
            grant = 4'b0011;
        end

        casez (active_q)
            4'b1???: next_ptr = 2'd0;
            4'b01??: next_ptr = 2'd3;
            4'b001?: next_ptr = 2'd2;
            default: next_ptr = 2'd1;
        endcase

        case (state_q)
            S_IDLE: begin
                if (|pending_q) begin
                    active_d  = grant;
                    pending_d = (pending_q & ~grant) | accept;
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                start_d = active_q;
                mask_d  = '0;
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                done_all = mask_q | (bus.done_i & active_q);
                mask_d   = done_all;
                tmo_d    = tmo_q + TMO_W'(1);
                if (done_all == active_q) begin
                    finish = 1'b1;
                end else if (tmo_d == TMO_MAX) begin
                    finish = 1'b1;
                    flag_d = 1'b1;
                    if (tcnt_q != '1) begin
                        tcnt_d = tcnt_q + CNT_W'(1);
                    end
                end
                if (finish) begin
                    state_d  = S_IDLE;
                    active_d = '0;
                    ptr_d    = next_ptr;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            active_q  <= '0;
            start_q   <= '0;
            mask_q    <= '0;
            ptr_q     <= '0;
            tmo_q     <= '0;
            drop_q    <= '0;
            tcnt_q    <= '0;
            flag_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            start_q   <= start_d;
            mask_q    <= mask_d;
            ptr_q     <= ptr_d;
            tmo_q     <= tmo_d;
            drop_q    <= drop_d;
            tcnt_q    <= tcnt_d;
            flag_q    <= flag_d;
        end
    end

    assign bus.start_o    = start_q;
    assign bus.busy_o     = (state_q != S_IDLE);
    assign bus.active_o   = active_q;
    assign bus.pending_o  = pending_q;
    assign bus.drop_cnt_o = drop_q;
    assign bus.tmo_cnt_o  = tcnt_q;
    assign bus.tmo_flag_o = flag_q;
endmodule

// File: tb/tb_ddr_op_scheduler.sv
// Bench for ddr_op_scheduler: directed scenarios plus randomized traffic
// checked cycle by cycle against a behavioural reference model.
module tb_ddr_op_scheduler;
    localparam int unsigned CNT_W = 8;
    localparam int          TMO   = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ddr_op_scheduler_if #(.CNT_W(CNT_W)) ifc ();

    ddr_op_scheduler #(.TMO_W(24), .TMO_MAX(24'd16), .CNT_W(CNT_W)) dut (
        .clk_i    (clk),
        .resetn_i (rst_n),
        .bus      (ifc)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: phase 0 idle, 1 launch, 2 wait; counters unbounded, clamped on compare.
    int         m_phase, m_left, m_ptr, m_drop, m_tmo;
    logic [3:0] m_pend, m_act, m_start, m_got;
    bit         m_flag;
    int         eng_cnt[4];
    int         eng_lat[4];

    function automatic void model_reset();
        m_phase = 0; m_left = 0; m_ptr = 0; m_drop = 0; m_tmo = 0;
        m_pend = '0; m_act = '0; m_start = '0; m_got = '0; m_flag = 1'b0;
        for (int k = 0; k < 4; k++) eng_cnt[k] = 0;
    endfunction

    function automatic void model_clk(input logic [3:0] req, input logic [3:0] done);
        logic [3:0] nxt_pend, nxt_start, grant;
        bit fin;
        int hi;
        nxt_pend = m_pend; nxt_start = '0; grant = '0; fin = 0; hi = 0;
        for (int k = 0; k < 4; k++)
            if (req[k]) begin
                if (m_pend[k] || m_act[k]) m_drop++;
                else nxt_pend[k] = 1'b1;
            end
        case (m_phase)
            0: if (m_pend != 0) begin
                if (m_pend[0] && m_pend[1]) grant = 4'b0011;
                else
                    for (int i = 0; i < 4; i++)
                        if (grant == 0 && m_pend[(m_ptr + i) % 4]) grant[(m_ptr + i) % 4] = 1'b1;
                nxt_pend = nxt_pend & ~grant;
                m_act = grant;
                m_phase = 1;
            end
            1: begin
                nxt_start = m_act; m_got = '0; m_left = TMO; m_phase = 2;
            end
            default: begin
                m_got = m_got | (done & m_act);
                if (m_got == m_act) fin = 1;
                else begin
                    m_left--;
                    if (m_left == 0) begin m_tmo++; m_flag = 1'b1; fin = 1; end
                end
                if (fin) begin
                    for (int k = 0; k < 4; k++) if (m_act[k]) hi = k;
                    m_ptr = (hi + 1) % 4;
                    m_act = '0;
                    m_phase = 0;
                end
            end
        endcase
        m_pend = nxt_pend;
        m_start = nxt_start;
    endfunction

    function automatic logic [29:0] exp_vec();
        int d, t;
        d = (m_drop > 255) ? 255 : m_drop;
        t = (m_tmo > 255) ? 255 : m_tmo;
        return {m_start, m_act, (m_phase != 0), m_pend, 8'(d), 8'(t), m_flag};
    endfunction

    function automatic logic [29:0] dut_vec();
        return {ifc.start_o, ifc.active_o, ifc.busy_o, ifc.pending_o,
                ifc.drop_cnt_o, ifc.tmo_cnt_o, ifc.tmo_flag_o};
    endfunction

    // Engine stand-ins: answer eng_lat[k] cycles after start (0 = never).
    function automatic logic [3:0] auto_done();
        logic [3:0] d;
        d = '0;
        for (int k = 0; k < 4; k++) begin
            if (eng_cnt[k] == 1) d[k] = 1'b1;
            if (eng_cnt[k] > 0) eng_cnt[k]--;
            if (ifc.start_o[k]) eng_cnt[k] = eng_lat[k];
        end
        return d;
    endfunction

    task automatic cycle(input logic [3:0] req, input logic [3:0] done);
        ifc.req_i = req;
        ifc.done_i = done;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_clk(req, done);
        #1;
        ifc.req_i = '0;
        ifc.done_i = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle('0, '0);
        cycle('0, '0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        cycle('0, '0);
        cycle('0, '0);
        checks++; if (ifc.start_o !== 4'b0) begin failures++; $display("FAIL reset_start: got %b expected 0000", ifc.start_o); end
        checks++; if (ifc.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", ifc.busy_o); end
        checks++; if (ifc.active_o !== 4'b0) begin failures++; $display("FAIL reset_active: got %b expected 0000", ifc.active_o); end
        checks++; if (ifc.pending_o !== 4'b0) begin failures++; $display("FAIL reset_pending: got %b expected 0000", ifc.pending_o); end
        checks++; if (ifc.drop_cnt_o !== 8'd0) begin failures++; $display("FAIL reset_drop: got %0d expected 0", ifc.drop_cnt_o); end
        checks++; if (ifc.tmo_cnt_o !== 8'd0 || ifc.tmo_flag_o !== 1'b0) begin failures++; $display("FAIL reset_tmo: got %0d/%b expected 0/0", ifc.tmo_cnt_o, ifc.tmo_flag_o); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_op();
        cycle(4'b0100, '0);
        checks++; if (ifc.pending_o !== 4'b0100) begin failures++; $display("FAIL single_pending: got %b expected 0100", ifc.pending_o); end
        cycle('0, '0);
        checks++; if (ifc.busy_o !== 1'b1 || ifc.start_o !== 4'b0) begin failures++; $display("FAIL single_launch: got busy=%b start=%b expected 1/0000", ifc.busy_o, ifc.start_o); end
        cycle('0, '0);
        checks++; if (ifc.start_o !== 4'b0100) begin failures++; $display("FAIL single_start: got %b expected 0100", ifc.start_o); end
        for (int c = 4; c <= 10; c++) begin
            cycle('0, '0);
            checks++; if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL single_model c%0d: got %h expected %h", c, dut_vec(), exp_vec()); end
        end
        checks++; if (ifc.busy_o !== 1'b1 || ifc.start_o !== 4'b0) begin failures++; $display("FAIL single_wait: got busy=%b start=%b expected 1/0000", ifc.busy_o, ifc.start_o); end
        cycle('0, 4'b0100);
        checks++; if (ifc.busy_o !== 1'b0 || ifc.active_o !== 4'b0) begin failures++; $display("FAIL single_done: got busy=%b active=%b expected 0/0000", ifc.busy_o, ifc.active_o); end
    endtask

    task automatic test_pair();
        logic [3:0] starts[$];
        int pair_at, fall_at;
        logic [3:0] req;
        pair_at = -1; fall_at = -1;
        eng_lat[3] = 6; eng_lat[1] = 2; eng_lat[0] = 7; eng_lat[2] = 3;
        cycle(4'b1000, '0);
        cycle('0, '0);
        cycle('0, '0);
        if (ifc.start_o != 0) starts.push_back(ifc.start_o);
        for (int i = 0; i < 30; i++) begin
            req = (i == 0) ? 4'b0001 : (i == 1) ? 4'b0010 : 4'b0000;
            cycle(req, auto_done());
            checks++; if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL pair_model i%0d: got %h expected %h", i, dut_vec(), exp_vec()); end
            if (ifc.start_o != 0) starts.push_back(ifc.start_o);
            if (ifc.start_o === 4'b0011) pair_at = i;
            if (pair_at >= 0 && fall_at < 0 && ifc.busy_o === 1'b0) fall_at = i;
        end
        checks++; if (starts.size() != 2) begin failures++; $display("FAIL pair_count: got %0d expected 2", starts.size()); end
        else begin
            checks++; if (starts[0] !== 4'b1000 || starts[1] !== 4'b0011) begin failures++; $display("FAIL pair_order: got %b,%b expected 1000,0011", starts[0], starts[1]); end
        end
        checks++; if (fall_at - pair_at != 8) begin failures++; $display("FAIL pair_busy: got %0d expected 8 cycles", fall_at - pair_at); end
    endtask

    task automatic test_round_robin();
        logic [3:0] starts[$];
        logic [3:0] req;
        bit sent;
        sent = 0;
        do_reset();
        for (int k = 0; k < 4; k++) eng_lat[k] = 3;
        for (int i = 0; i < 40; i++) begin
            req = (i == 0) ? 4'b1100 : 4'b0000;
            if (!sent && i > 0 && ifc.busy_o === 1'b0 && ifc.pending_o === 4'b1000) begin
                req = 4'b0100; sent = 1;
            end
            cycle(req, auto_done());
            checks++; if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL rr_model i%0d: got %h expected %h", i, dut_vec(), exp_vec()); end
            if (ifc.start_o != 0) starts.push_back(ifc.start_o);
        end
        checks++; if (starts.size() != 3) begin failures++; $display("FAIL rr_count: got %0d expected 3", starts.size()); end
        else begin
            checks++; if (starts[0] !== 4'b0100 || starts[1] !== 4'b1000 || starts[2] !== 4'b0100) begin failures++; $display("FAIL rr_order: got %b,%b,%b expected 0100,1000,0100", starts[0], starts[1], starts[2]); end
        end
    endtask

    task automatic test_drops();
        int launches;
        launches = 0;
        do_reset();
        eng_lat[2] = 4;
        cycle(4'b0100, '0);
        cycle(4'b0100, '0);
        cycle(4'b0100, '0);
        for (int i = 0; i < 20; i++) begin
            if (ifc.start_o[2] === 1'b1) launches++;
            cycle('0, auto_done());
        end
        checks++; if (ifc.drop_cnt_o !== 8'd2) begin failures++; $display("FAIL drop_three: got %0d expected 2", ifc.drop_cnt_o); end
        checks++; if (launches != 1) begin failures++; $display("FAIL drop_launches: got %0d expected 1", launches); end
        for (int k = 0; k < 4; k++) eng_lat[k] = 5;
        for (int i = 0; i < 120; i++) begin
            cycle(4'b1111, auto_done());
            checks++; if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL drop_model i%0d: got %h expected %h", i, dut_vec(), exp_vec()); end
        end
        checks++; if (ifc.drop_cnt_o !== 8'd255) begin failures++; $display("FAIL drop_saturate: got %0d expected 255", ifc.drop_cnt_o); end
    endtask

    task automatic test_timeout();
        int busy_cycles;
        busy_cycles = 0;
        do_reset();
        for (int k = 0; k < 4; k++) eng_lat[k] = 0;
        cycle(4'b0001, '0);
        for (int i = 0; i < 40; i++) begin
            cycle('0, '0);
            if (ifc.busy_o === 1'b1) busy_cycles++;
        end
        checks++; if (busy_cycles != TMO + 1) begin failures++; $display("FAIL tmo_length: got %0d expected %0d busy cycles", busy_cycles, TMO + 1); end
        checks++; if (ifc.tmo_cnt_o !== 8'd1 || ifc.tmo_flag_o !== 1'b1) begin failures++; $display("FAIL tmo_count: got %0d/%b expected 1/1", ifc.tmo_cnt_o, ifc.tmo_flag_o); end
        for (int i = 0; i < 3; i++) begin
            cycle('0, 4'b0001);
            checks++; if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL tmo_late_done i%0d: got %h expected %h", i, dut_vec(), exp_vec()); end
        end
        checks++; if (ifc.busy_o !== 1'b0 || ifc.tmo_cnt_o !== 8'd1) begin failures++; $display("FAIL tmo_after: got busy=%b cnt=%0d expected 0/1", ifc.busy_o, ifc.tmo_cnt_o); end
    endtask

    task automatic test_reset_mid_wait();
        cycle(4'b0011, '0);
        cycle('0, '0);
        cycle('0, '0);
        checks++; if (ifc.start_o !== 4'b0011) begin failures++; $display("FAIL rstw_pair_start: got %b expected 0011", ifc.start_o); end
        cycle(4'b0100, '0);
        cycle('0, '0);
        rst_n = 1'b0;
        cycle('0, '0);
        rst_n = 1'b1;
        checks++; if (dut_vec() !== 30'd0) begin failures++; $display("FAIL rstw_outputs: got %h expected 0", dut_vec()); end
        for (int i = 0; i < 10; i++) begin
            cycle('0, '0);
            checks++; if (ifc.start_o !== 4'b0 || ifc.busy_o !== 1'b0) begin failures++; $display("FAIL rstw_idle i%0d: got start=%b busy=%b expected 0000/0", i, ifc.start_o, ifc.busy_o); end
        end
    endtask

    task automatic test_random();
        logic [3:0] req, done;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
            for (int k = 0; k < 4; k++) eng_lat[k] = $urandom_range(1, 20);
            done = auto_done();
            req = '0;
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 5) == 0) req[k] = 1'b1;
                if ($urandom_range(0, 19) == 0) done[k] = 1'b1;
            end
            cycle(req, done);
            checks++; if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL random_model i%0d: got %h expected %h", i, dut_vec(), exp_vec()); end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        ifc.req_i = '0;
        ifc.done_i = '0;
        model_reset();
        for (int k = 0; k < 4; k++) eng_lat[k] = 0;
        test_reset();
        test_single_op();
        test_pair();
        test_round_robin();
        test_drops();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ddr_op_scheduler.md
Name: ddr_op_scheduler

Overview:
- Serializes DDR3 access requests from the register-level start pulses: pattern write, pattern read/check, DIGIFIFO-to-DDR, DDR-to-MEMFIFO.
- Holds pending requests and grants exactly one engine at a time, round-robin.
- Exception: a pattern WR and RD pending together are launched as a simultaneous RW pair.
- Sits between the enable-to-pulse register logic and the pattern generator / FIFO transfer engines; tracks completion, timeouts and dropped requests.

Parameters:
TMO_W, 24, width of per-operation timeout counter
TMO_MAX, 24'hFFFFFF, cycles in WAIT before forced abort
CNT_W, 8, width of drop/timeout saturating counters

Ports:
clk_i  in  1  system clock
resetn_i  in  1  synchronous active-low reset
req_i  in  4  one-cycle start pulses: [0] pg_wr, [1] pg_rd, [2] fifo_wr, [3] fifo_rd
done_i  in  4  one-cycle completion strobes from the matching engines, same bit order
start_o  out  4  one-cycle launch pulses to the engines, same bit order
busy_o  out  1  high while any operation is granted (LAUNCH or WAIT)
active_o  out  4  one-hot (or 2'b11 in bits [1:0] for an RW pair) granted engine(s)
pending_o  out  4  pending request bits
drop_cnt_o  out  CNT_W  saturating count of requests dropped
tmo_cnt_o  out  CNT_W  saturating count of timed-out operations
tmo_flag_o  out  1  sticky timeout flag; cleared by reset only

Behaviour:
- Reset (resetn_i low at a clk_i edge):
  - All outputs 0; pending cleared; state IDLE; RR pointer = 0.
  - Reset mid-operation abandons the op; no start_o is issued afterwards.
- Pending capture:
  - req_i[k]=1 sets pending[k] on the next edge.
  - If pending[k] is already 1, or k is currently active, the request is dropped: drop_cnt_o += 1, saturating at all-ones.
  - Several bits in one cycle are each captured or dropped independently; drop_cnt increments by the number dropped, saturating.
- States: IDLE, LAUNCH, WAIT.
- IDLE: if pending != 0, select grant and go to LAUNCH next cycle.
  - Pair rule: pending[0] & pending[1] both set → grant 4'b0011, regardless of RR pointer.
  - Otherwise grant the first pending bit at or after the RR pointer, wrapping 3→0.
  - Granted pending bits clear at the transition edge; active_o loads the grant.
- LAUNCH: exactly one cycle.
  - start_o = active_o.
  - For a pair, start_o[0] and start_o[1] assert in the same cycle.
  - Timeout counter cleared; go to WAIT.
- WAIT: collect done_i & active_o into a done mask.
  - When done mask == active_o (pair needs both dones, in any cycles, possibly the same cycle): go to IDLE.
  - On that exit, active_o and busy_o drop, and RR pointer = (highest granted index + 1) mod 4.
  - done_i for a non-active engine is ignored.
  - Timeout counter increments each WAIT cycle. When it reaches TMO_MAX without completion:
    - tmo_cnt_o += 1 (saturating), tmo_flag_o set.
    - Return to IDLE and advance RR pointer as for normal completion.
- Minimum spacing: back-to-back operations have ≥1 IDLE cycle between done and the next start_o. Request→start latency from IDLE is 3 cycles (capture, grant, LAUNCH).
- busy_o = (state != IDLE), registered.
- done_i arriving in LAUNCH is not counted; engines respond ≥1 cycle after start_o.

Test Plan:
- Single op: req_i=4'b0100 at cycle 0 → start_o=4'b0100 at cycle 3 for exactly 1 cycle, busy_o high from cycle 2; done_i[2] at cycle 10 → busy_o low at cycle 11, active_o=0.
- RW pair: req_i[0] at cycle 0, req_i[1] at cycle 1 while busy with fifo_rd → after fifo_rd done, start_o=4'b0011 in one cycle; done_i[1] then done_i[0] 5 cycles later → busy_o stays high until the second done.
- Round-robin: req_i=4'b1100 together with RR pointer=0 → grant order fifo_wr then fifo_rd; a later fifo_wr request while fifo_rd pending is served after fifo_rd.
- Drops: req_i[2] pulsed 3 times while fifo_wr pending/active → one launch, drop_cnt_o=2; 300 drops with CNT_W=8 → drop_cnt_o=255.
- Timeout: TMO_MAX=16, start pg_wr with no done → returns to IDLE after 16 WAIT cycles, tmo_cnt_o=1, tmo_flag_o=1; a late done_i[0] is ignored.
- Reset mid-WAIT: resetn_i low for 1 cycle during pair WAIT → all outputs 0, pending 0, no spurious start_o after release.
